// File: rtl/mips_data_memory_if.sv
// Request/response bus between the MEM-stage controller (master) and the data memory (slave).
interface mips_data_memory_if;
    logic        req;
    logic        writeEnable;
    logic [1:0]  size;
    logic        signExt;
    logic [31:0] Address;
    logic [31:0] writeData;
    logic        ready;
    logic [31:0] MemData;
    logic        error;
    logic        busy;

    modport master (
        output req, writeEnable, size, signExt, Address, writeData,
        input  ready, MemData, error, busy
    );

    modport slave (
        input  req, writeEnable, size, signExt, Address, writeData,
        output ready, MemData, error, busy
    );
endinterface

// File: rtl/mips_data_memory.sv
// Multicycle byte/half/word data memory with req/ready handshake and configurable wait states.
// Illegal (misaligned, bad size, out-of-range) requests are answered with an error response.
module mips_data_memory #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    mips_data_memory_if.slave   bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

    localparam int ADDR_W = DEPTH_LOG2 + 2;

    logic [31:0]           r_mem [2**DEPTH_LOG2];
    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_count;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_signExt;
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_wdata;
    logic                  r_error;
    logic [31:0]           r_memData;

    logic                  w_illegal;
    logic [DEPTH_LOG2-1:0] w_wordIdx;
    logic [31:0]           w_word;
    logic [31:0]           w_shifted;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_loadData;
    logic [3:0]            w_byteEn;
    logic [31:0]           w_storeData;

    always_comb begin
        w_illegal = (bus.size == 2'b11)
                  || (bus.size == 2'b01 && bus.Address[0] != 1'b0)
                  || (bus.size == 2'b10 && bus.Address[1:0] != 2'b00)
                  || (bus.Address[31:ADDR_W] != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (w_illegal)             w_nextState = ST_RESP;
                    else if (WAIT_CYCLES == 0) w_nextState = ST_ACCESS;
                    else                       w_nextState = ST_WAIT;
                end
            end
            ST_WAIT:   if (r_count == 4'd1) w_nextState = ST_ACCESS;
            ST_ACCESS: w_nextState = ST_RESP;
            ST_RESP:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_we      <= 1'b0;
            r_size    <= '0;
            r_signExt <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_error   <= 1'b0;
            r_memData <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we      <= bus.writeEnable;
                        r_size    <= bus.size;
                        r_signExt <= bus.signExt;
                        r_addr    <= bus.Address[ADDR_W-1:0];
                        r_wdata   <= bus.writeData;
                        r_error   <= w_illegal;
                        r_count   <= 4'(WAIT_CYCLES);
                    end
                end
                ST_WAIT:   r_count <= r_count - 4'd1;
                ST_ACCESS: begin
                    if (!r_we) r_memData <= w_loadData;
                    r_error <= 1'b0;
                end
                ST_RESP:   r_error <= 1'b0;
                default:   r_error <= 1'b0;
            endcase
        end
    end

    always_comb begin
        w_wordIdx = r_addr[ADDR_W-1:2];
        w_word    = r_mem[w_wordIdx];
        w_shifted = w_word >> {r_addr[1:0], 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_size)
            2'b00:   w_loadData = {{24{r_signExt & w_byte[7]}}, w_byte};
            2'b01:   w_loadData = {{16{r_signExt & w_half[15]}}, w_half};
            default: w_loadData = w_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        case (r_size)
            2'b00: begin
                w_byteEn    = 4'b0001 << r_addr[1:0];
                w_storeData = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_byteEn    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{r_wdata[15:0]}};
            end
            default: begin
                w_byteEn    = 4'b1111;
                w_storeData = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && r_state == ST_ACCESS && r_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_byteEn[k]) r_mem[w_wordIdx][8*k +: 8] <= w_storeData[8*k +: 8];
            end
        end
    end

    assign bus.ready   = (r_state == ST_RESP);
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.error   = r_error;
    assign bus.MemData = r_memData;

endmodule

// File: tb/tb_mips_data_memory.sv
// Scoreboard bench for mips_data_memory: expected responses are queued when a request is driven
// and compared when ready pulses.
module tb_mips_data_memory;

    localparam int WAIT_CYCLES = 2;
    localparam int LEGAL_LAT   = WAIT_CYCLES + 2;
    localparam int BUDGET      = 20;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } expect_t;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;
    int   readyCount;
    expect_t sbQ[$];

    mips_data_memory_if bus();

    mips_data_memory #(.DEPTH_LOG2(8), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Pops the oldest expected response and compares it with what the DUT presents now.
    task automatic checkResponse(input string tag, input int cycles);
        expect_t e;
        if (sbQ.size() == 0) begin
            checkOutput({tag, "_unexpected_ready"}, 32'd1, 32'd0);
            return;
        end
        e = sbQ.pop_front();
        checkOutput({tag, "_data"}, bus.MemData, e.data);
        checkOutput({tag, "_err"}, {31'd0, bus.error}, {31'd0, e.err});
        if (cycles > 0) checkOutput({tag, "_lat"}, 32'(cycles), 32'(e.lat));
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr);
        int cycles;
        sbQ.push_back('{expData, expErr, expErr ? 1 : LEGAL_LAT});
        @(negedge clk);
        bus.writeEnable = we;
        bus.size        = sz;
        bus.signExt     = sx;
        bus.Address     = addr;
        bus.writeData   = wdata;
        bus.req         = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            bus.req = 1'b0;
            cycles++;
        end while (!bus.ready && cycles < BUDGET);
        if (!bus.ready) begin
            checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
            void'(sbQ.pop_front());
        end else begin
            checkResponse(tag, cycles);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_ready_drop"}, {31'd0, bus.ready}, 32'd0);
        checkOutput({tag, "_err_clear"}, {31'd0, bus.error}, 32'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        bus.req = 1'b0; bus.writeEnable = 1'b0; bus.size = 2'b10; bus.signExt = 1'b0;
        bus.Address = '0; bus.writeData = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_ready", {31'd0, bus.ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_error", {31'd0, bus.error}, 32'd0);
        checkOutput("rst_memdata", bus.MemData, 32'd0);

        $display("[TB] word store/load");
        applyStimulus("sw_0c", 1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF, 32'h0, 1'b0);
        applyStimulus("lw_0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hDEADBEEF, 1'b0);

        $display("[TB] sub-word loads");
        applyStimulus("lb_0f", 1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, 32'hFFFFFFDE, 1'b0);
        applyStimulus("lbu_0f", 1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 32'h000000DE, 1'b0);
        applyStimulus("lh_0c", 1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 32'hFFFFBEEF, 1'b0);
        applyStimulus("lhu_0e", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'h0000DEAD, 1'b0);
        applyStimulus("lbu_0c", 1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 32'h000000EF, 1'b0);

        $display("[TB] partial stores");
        applyStimulus("sb_0d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'hAAAAAA11, 32'h000000EF, 1'b0);
        applyStimulus("lw_sb", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hDEAD11EF, 1'b0);
        applyStimulus("sh_0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'hBBBB2233, 32'hDEAD11EF, 1'b0);
        applyStimulus("lw_sh", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h223311EF, 1'b0);

        $display("[TB] illegal accesses");
        applyStimulus("err_lw_0d", 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0, 32'h223311EF, 1'b1);
        applyStimulus("err_sh_01", 1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF, 32'h223311EF, 1'b1);
        applyStimulus("err_size3", 1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, 32'h223311EF, 1'b1);
        applyStimulus("err_range", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h223311EF, 1'b1);
        applyStimulus("err_sw_rng", 1'b1, 2'b10, 1'b0, 32'h40C, 32'h55555555, 32'h223311EF, 1'b1);
        applyStimulus("lw_after_err", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h223311EF, 1'b0);

        $display("[TB] req held high for 10 cycles");
        sbQ.push_back('{32'h223311EF, 1'b0, LEGAL_LAT});
        sbQ.push_back('{32'h223311EF, 1'b0, LEGAL_LAT});
        readyCount = 0;
        @(negedge clk);
        bus.writeEnable = 1'b0; bus.size = 2'b10; bus.Address = 32'h0C; bus.req = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) bus.req = 1'b0;
            if (bus.ready) begin
                readyCount++;
                checkResponse("held", 0);
            end
        end
        checkOutput("held_count", 32'(readyCount), 32'd2);
        checkOutput("held_sb_empty", 32'(sbQ.size()), 32'd0);
        checkOutput("held_idle", {31'd0, bus.busy}, 32'd0);

        $display("[TB] req pulsed during WAIT");
        sbQ.push_back('{32'h00002233, 1'b0, LEGAL_LAT});
        readyCount = 0;
        @(negedge clk);
        bus.writeEnable = 1'b0; bus.size = 2'b01; bus.signExt = 1'b0; bus.Address = 32'h0E; bus.req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            bus.req = (c == 1);
            if (c == 1) bus.Address = 32'h400;
            if (c <= 3) checkOutput($sformatf("glitch_busy_%0d", c), {31'd0, bus.busy}, 32'd1);
            if (bus.ready) begin
                readyCount++;
                checkResponse("glitch", c);
            end
        end
        checkOutput("glitch_count", 32'(readyCount), 32'd1);

        $display("[TB] reset during store");
        applyStimulus("sw_clear", 1'b1, 2'b10, 1'b0, 32'h10, 32'h00000000, 32'h00002233, 1'b0);
        readyCount = 0;
        @(negedge clk);
        bus.writeEnable = 1'b1; bus.size = 2'b10; bus.Address = 32'h10; bus.writeData = 32'h12345678;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        checkOutput("rst_mid_wait", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_mid_ready", {31'd0, bus.ready}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_mid_error", {31'd0, bus.error}, 32'd0);
        checkOutput("rst_mid_memdata", bus.MemData, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.ready) readyCount++;
        end
        checkOutput("rst_mid_no_ready", 32'(readyCount), 32'd0);
        applyStimulus("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b0);
        applyStimulus("lw_0c_end", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h223311EF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
